// File: rtl/storage_arb_pkg.sv
// Shared types and default sizing for the storage arbiter.
// Round-robin build: define STORAGE_ARB_RR_EN.
package storage_arb_pkg;

    localparam int NREQ_DEF  = 4;
    localparam int WIDTH_DEF = 32;
    localparam int DEPTH_DEF = 16;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } arb_state_e;

endpackage

// File: rtl/rr_picker.sv
// Rotated-priority one-hot picker: the first valid bit at or after
// start (wrapping at N) wins.
module rr_picker #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  valid,
    input  logic [IW-1:0] start,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx
);

    int            j;
    logic          found;
    logic [IW-1:0] jj;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        jj    = '0;
        for (int k = 0; k < N; k++) begin
            j = int'(start) + k;
            if (j >= N) begin
                j = j - N;
            end
            jj = IW'(j);
            if (!found && valid[jj]) begin
                found     = 1'b1;
                grant[jj] = 1'b1;
                idx       = jj;
            end
        end
    end

endmodule

// File: rtl/storage_arbiter.sv
// N-requester arbiter in front of a single-port-per-direction storage.
// STORAGE_ARB_RR_EN selects round-robin; otherwise fixed lowest-index priority.
module storage_arbiter
    import storage_arb_pkg::*;
#(
    parameter int NREQ  = NREQ_DEF,
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF,
    localparam int AW   = $clog2(DEPTH),
    localparam int IW   = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ-1:0]      req_we,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ*WIDTH-1:0] req_wdata,
    output logic [NREQ-1:0]      req_ready,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IW-1:0]        rsp_id,
    output logic [WIDTH-1:0]     rsp_rdata,
    output logic                 st_wr_en,
    output logic [AW-1:0]        st_wr_addrs,
    output logic [WIDTH-1:0]     st_wr_data,
    output logic                 st_rd_en,
    output logic [AW-1:0]        st_rd_addrs,
    input  logic [WIDTH-1:0]     st_rd_data
);

    arb_state_e       state;
    logic             stall;
    logic             acc;
    logic             rd_acc;
    logic             wr_ok;
    logic             in_range;
    logic             g_we;
    logic [NREQ-1:0]  grant;
    logic [IW-1:0]    gidx;
    logic [IW-1:0]    start;
    logic [AW-1:0]    g_addr;
    logic [WIDTH-1:0] g_wdata;

`ifdef STORAGE_ARB_RR_EN
    logic [IW-1:0] ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (acc) begin
            ptr <= (gidx == IW'(NREQ - 1)) ? '0 : gidx + 1'b1;
        end
    end

    assign start = ptr;
`else
    assign start = '0;
`endif

    rr_picker #(
        .N  (NREQ),
        .IW (IW)
    ) u_pick (
        .valid (req_valid),
        .start (start),
        .grant (grant),
        .idx   (gidx)
    );

    // A held response blocks every requester until it is consumed.
    assign stall     = (state == RESP) && !rsp_ready;
    assign req_ready = stall ? '0 : grant;
    assign acc       = |req_ready;

    assign g_we     = req_we[gidx];
    assign g_addr   = req_addr[int'(gidx)*AW +: AW];
    assign g_wdata  = req_wdata[int'(gidx)*WIDTH +: WIDTH];
    assign in_range = {1'b0, g_addr} < (AW+1)'(DEPTH);

    assign wr_ok  = acc && g_we && in_range;
    assign rd_acc = acc && !g_we;

    always_comb begin
        st_wr_en    = 1'b0;
        st_wr_addrs = '0;
        st_wr_data  = '0;
        st_rd_en    = 1'b0;
        st_rd_addrs = '0;
        if (wr_ok) begin
            st_wr_en    = 1'b1;
            st_wr_addrs = g_addr;
            st_wr_data  = g_wdata;
        end
        if (rd_acc) begin
            st_rd_en    = 1'b1;
            st_rd_addrs = g_addr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rsp_id    <= '0;
            rsp_rdata <= '0;
        end else begin
            if (rd_acc) begin
                state     <= RESP;
                rsp_id    <= gidx;
                rsp_rdata <= in_range ? st_rd_data : '0;
            end else if (state == RESP && rsp_ready) begin
                state <= IDLE;
            end
        end
    end

    assign rsp_valid = (state == RESP);

endmodule
